// File: rtl/ppi_bus_arbiter.sv
// ============================================================================
//  ppi_bus_arbiter : shares the i8255 register file between the Z80 bus and
//                    an aux master (setup / strobe / ack sequencing)
//  Revision 1.0
// ============================================================================
`default_nettype none

module ppi_bus_arbiter #(
  parameter int ACCESS_CYCLES = 2,
  parameter int STARVE_LIMIT  = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [1:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_ack,
  output logic       cpu_wait_n,
  input  logic       aux_req,
  input  logic       aux_we,
  input  logic [1:0] aux_addr,
  input  logic [7:0] aux_wdata,
  output logic       aux_ack,
  output logic [7:0] rdata,
  output logic       ppi_cs,
  output logic       ppi_rd,
  output logic       ppi_wr,
  output logic [1:0] ppi_addr,
  output logic [7:0] ppi_wdata,
  input  logic [7:0] ppi_rdata,
  output logic       busy
);

  localparam logic [3:0] CNT_INIT  = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0] STARVE_TH = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] starve_q, starve_d;
  logic       owner_q, owner_d;   // 1 = aux owns the current access
  logic       we_q, we_d;
  logic [1:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic       cs_q, cs_d, rd_q, rd_d, wr_q, wr_d;
  logic       cpu_ack_q, cpu_ack_d, aux_ack_q, aux_ack_d, busy_q, busy_d;
  logic       aux_win;

  assign aux_win = aux_req && (!cpu_req || (starve_q >= STARVE_TH));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    starve_d = starve_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_req || aux_req) begin
          owner_d = aux_win;
          we_d    = aux_win ? aux_we    : cpu_we;
          addr_d  = aux_win ? aux_addr  : cpu_addr;
          wdata_d = aux_win ? aux_wdata : cpu_wdata;
          state_d = S_SETUP;
        end
        // Aux only accumulates credit while it is actively losing to the CPU.
        if (!aux_req || aux_win) begin
          starve_d = 4'd0;
        end else if (starve_q != 4'hF) begin
          starve_d = starve_q + 4'd1;
        end
      end
      S_SETUP: begin
        cnt_d   = CNT_INIT;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          if (!we_q) rdata_d = ppi_rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they leave the flops glitch-free.
    cs_d      = (state_d == S_SETUP) || (state_d == S_ACCESS);
    rd_d      = (state_d == S_ACCESS) && !we_d;
    wr_d      = (state_d == S_ACCESS) && we_d;
    cpu_ack_d = (state_d == S_DONE) && !owner_d;
    aux_ack_d = (state_d == S_DONE) && owner_d;
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      starve_q  <= 4'd0;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 2'd0;
      wdata_q   <= 8'd0;
      rdata_q   <= 8'd0;
      cs_q      <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      cpu_ack_q <= 1'b0;
      aux_ack_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      starve_q  <= starve_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      cs_q      <= cs_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      cpu_ack_q <= cpu_ack_d;
      aux_ack_q <= aux_ack_d;
      busy_q    <= busy_d;
    end
  end

  assign cpu_wait_n = !(cpu_req && !cpu_ack_q);
  assign cpu_ack    = cpu_ack_q;
  assign aux_ack    = aux_ack_q;
  assign rdata      = rdata_q;
  assign ppi_cs     = cs_q;
  assign ppi_rd     = rd_q;
  assign ppi_wr     = wr_q;
  assign ppi_addr   = addr_q;
  assign ppi_wdata  = wdata_q;
  assign busy       = busy_q;

endmodule

`default_nettype wire
